hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_pkg.sv | 62 ++++++
 rtl/hazard_ctrl_fwd_detect.sv | 35 +++
 rtl/hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_hazard_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: bypass selects, stall causes
// and the bundle of stall/bubble/flush controls each cause drives.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_FILE   = 2'b00,
    FWD_EX     = 2'b01,
    FWD_MM_ALU = 2'b10,
    FWD_MM_MEM = 2'b11
  } fwd_sel_e;

  typedef enum logic [2:0] {
    RUN,
    LOAD_USE,
    BRANCH,
    MC_BUSY,
    MEM_WAIT
  } hz_cause_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_id;
    logic stall_ex;
    logic stall_mm;
    logic bubble_ex;
    logic bubble_mm;
    logic bubble_wb;
    logic flush_id;
  } hz_ctrl_t;

  function automatic hz_ctrl_t cause_ctrl(input hz_cause_e cause);
    hz_ctrl_t c;
    c = '0;
    case (cause)
      MEM_WAIT: begin
        c.stall_pc  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.stall_mm  = 1'b1;
        c.bubble_wb = 1'b1;
      end
      MC_BUSY: begin
        c.stall_pc  = 1'b1;
        c.stall_id  = 1'b1;
        c.stall_ex  = 1'b1;
        c.bubble_mm = 1'b1;
      end
      BRANCH: begin
        c.flush_id  = 1'b1;
        c.bubble_ex = 1'b1;
      end
      LOAD_USE: begin
        c.stall_pc  = 1'b1;
        c.stall_id  = 1'b1;
        c.bubble_ex = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_detect.sv
// Per-operand dependency check: picks the bypass source and flags a dependency
// on a load still in EX (data not yet available, so the operand must wait).
module fwd_detect
  import hazard_pkg::*;
#(
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] rs,
  input  logic [IDX_W-1:0] ex_rd,
  input  logic             ex_wr_reg_en,
  input  logic             ex_is_load,
  input  logic [IDX_W-1:0] mm_rd,
  input  logic             mm_wr_reg_en,
  input  logic             mm_is_load,
  output fwd_sel_e         sel,
  output logic             ex_load_match
);

  logic ex_hit;
  logic mm_hit;

  always_comb begin
    ex_hit        = (rs != '0) && ex_wr_reg_en && (rs == ex_rd);
    mm_hit        = (rs != '0) && mm_wr_reg_en && (rs == mm_rd);
    ex_load_match = ex_hit && ex_is_load;
    sel           = FWD_FILE;
    // The youngest producer wins; an EX load shadows any older MM match.
    if (ex_hit) begin
      sel = ex_is_load ? FWD_FILE : FWD_EX;
    end else if (mm_hit) begin
      sel = mm_is_load ? FWD_MM_MEM : FWD_MM_ALU;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand bypass selection, prioritised stall/flush
// generation, memory-wait timeout detection and stall/flush statistics.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter  int REG_NUM     = 32,
  parameter  int MEM_TIMEOUT = 255,
  localparam int IDX_W       = $clog2(REG_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [IDX_W-1:0] id_rs1,
  input  logic [IDX_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [IDX_W-1:0] ex_rd,
  input  logic             ex_wr_reg_en,
  input  logic             ex_is_load,
  input  logic             ex_mc_start,
  input  logic             ex_mc_done,
  input  logic             branch_taken,
  input  logic [IDX_W-1:0] mm_rd,
  input  logic             mm_wr_reg_en,
  input  logic             mm_is_load,
  input  logic             mm_mem_req,
  input  logic             mm_mem_ready,
  output logic [1:0]       fwd_sel_rs1,
  output logic [1:0]       fwd_sel_rs2,
  output logic             stall_pc,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mm,
  output logic             bubble_ex,
  output logic             bubble_mm,
  output logic             bubble_wb,
  output logic             flush_id,
  output logic             mem_timeout,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_MAX = CW'(MEM_TIMEOUT);

  logic [IDX_W-1:0] rs_src [2];
  fwd_sel_e         sel_raw [2];
  logic [1:0]       ex_ld_hit;
  logic [1:0]       uses_rs;

  assign rs_src[0] = id_rs1;
  assign rs_src[1] = id_rs2;
  assign uses_rs   = {id_uses_rs2, id_uses_rs1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_operand
      fwd_detect #(.IDX_W(IDX_W)) u_fwd_detect (
        .rs            (rs_src[gi]),
        .ex_rd         (ex_rd),
        .ex_wr_reg_en  (ex_wr_reg_en),
        .ex_is_load    (ex_is_load),
        .mm_rd         (mm_rd),
        .mm_wr_reg_en  (mm_wr_reg_en),
        .mm_is_load    (mm_is_load),
        .sel           (sel_raw[gi]),
        .ex_load_match (ex_ld_hit[gi])
      );
    end
  endgenerate

  logic            mc_busy_reg;
  logic [CW-1:0]   wait_cnt_reg;
  logic [CW-1:0]   wait_cnt_next;
  logic            mem_timeout_reg;
  logic [31:0]     stall_cycles_reg;
  logic [31:0]     flush_count_reg;
  logic            load_use;
  logic            mc_stall;
  logic            mem_wait;
  hz_cause_e       cause;
  hz_ctrl_t        ctrl;

  always_comb begin
    load_use = id_valid && |(ex_ld_hit & uses_rs);
    mc_stall = (ex_mc_start || mc_busy_reg) && !ex_mc_done;
    mem_wait = mm_mem_req && !mm_mem_ready;
    // A branch under a higher-priority stall is deferred: the stall holds EX,
    // so the redirect is still presented once the stall clears.
    if (mem_wait)          cause = MEM_WAIT;
    else if (mc_stall)     cause = MC_BUSY;
    else if (branch_taken) cause = BRANCH;
    else if (load_use)     cause = LOAD_USE;
    else                   cause = RUN;
    ctrl = rst_n ? cause_ctrl(cause) : '0;
  end

  always_comb begin
    wait_cnt_next = '0;
    if (mem_wait) begin
      wait_cnt_next = (wait_cnt_reg == TMO_MAX) ? wait_cnt_reg : wait_cnt_reg + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mc_busy_reg      <= 1'b0;
      wait_cnt_reg     <= '0;
      mem_timeout_reg  <= 1'b0;
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (ex_mc_done)       mc_busy_reg <= 1'b0;
      else if (ex_mc_start) mc_busy_reg <= 1'b1;
      wait_cnt_reg     <= wait_cnt_next;
      mem_timeout_reg  <= mem_timeout_reg || (mem_wait && wait_cnt_next == TMO_MAX);
      stall_cycles_reg <= stall_cycles_reg + {31'd0, ctrl.stall_pc};
      flush_count_reg  <= flush_count_reg + {31'd0, ctrl.flush_id};
    end
  end

  assign fwd_sel_rs1  = rst_n ? sel_raw[0] : FWD_FILE;
  assign fwd_sel_rs2  = rst_n ? sel_raw[1] : FWD_FILE;
  assign stall_pc     = ctrl.stall_pc;
  assign stall_id     = ctrl.stall_id;
  assign stall_ex     = ctrl.stall_ex;
  assign stall_mm     = ctrl.stall_mm;
  assign bubble_ex    = ctrl.bubble_ex;
  assign bubble_mm    = ctrl.bubble_mm;
  assign bubble_wb    = ctrl.bubble_wb;
  assign flush_id     = ctrl.flush_id;
  assign mem_timeout  = mem_timeout_reg;
  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a rule-level model checked every negedge,
// plus literal expectations at the key points of each scenario.
module tb_hazard_ctrl;

  localparam int TMO = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic id_valid, id_uses_rs1, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mm_rd;
  logic ex_wr_reg_en, ex_is_load, ex_mc_start, ex_mc_done, branch_taken;
  logic mm_wr_reg_en, mm_is_load, mm_mem_req, mm_mem_ready;
  logic [1:0] fwd_sel_rs1, fwd_sel_rs2;
  logic stall_pc, stall_id, stall_ex, stall_mm, bubble_ex, bubble_mm, bubble_wb, flush_id;
  logic mem_timeout;
  logic [31:0] stall_cycles, flush_count;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_ctrl #(.REG_NUM(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_wr_reg_en(ex_wr_reg_en), .ex_is_load(ex_is_load),
    .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done), .branch_taken(branch_taken),
    .mm_rd(mm_rd), .mm_wr_reg_en(mm_wr_reg_en), .mm_is_load(mm_is_load),
    .mm_mem_req(mm_mem_req), .mm_mem_ready(mm_mem_ready),
    .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
    .stall_pc(stall_pc), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mm(stall_mm),
    .bubble_ex(bubble_ex), .bubble_mm(bubble_mm), .bubble_wb(bubble_wb), .flush_id(flush_id),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Model state
  logic        m_busy = 1'b0;
  int          m_wait = 0;
  logic        m_tmo = 1'b0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flush = '0;
  logic [7:0]  exp_ctrl = '0;

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (!rst_n || rs == 0) return 2'd0;
    if (ex_wr_reg_en && ex_rd == rs) return ex_is_load ? 2'd0 : 2'd1;
    if (mm_wr_reg_en && mm_rd == rs) return mm_is_load ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic dep_on_load(input logic [4:0] rs);
    return rs != 0 && ex_wr_reg_en && ex_is_load && ex_rd == rs;
  endfunction

  // {stall_pc, stall_id, stall_ex, stall_mm, bubble_ex, bubble_mm, bubble_wb, flush_id}
  function automatic logic [7:0] m_ctrl();
    logic lu;
    if (!rst_n) return 8'b0;
    lu = id_valid && ((id_uses_rs1 && dep_on_load(id_rs1)) || (id_uses_rs2 && dep_on_load(id_rs2)));
    if (mm_mem_req && !mm_mem_ready)                return 8'b1111_0010;
    if (!ex_mc_done && (ex_mc_start || m_busy))     return 8'b1110_0100;
    if (branch_taken)                               return 8'b0000_1001;
    if (lu)                                         return 8'b1100_1000;
    return 8'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_ctrl = m_ctrl();
    chk("stall_pc",  {31'd0, stall_pc},  {31'd0, exp_ctrl[7]});
    chk("stall_id",  {31'd0, stall_id},  {31'd0, exp_ctrl[6]});
    chk("stall_ex",  {31'd0, stall_ex},  {31'd0, exp_ctrl[5]});
    chk("stall_mm",  {31'd0, stall_mm},  {31'd0, exp_ctrl[4]});
    chk("bubble_ex", {31'd0, bubble_ex}, {31'd0, exp_ctrl[3]});
    chk("bubble_mm", {31'd0, bubble_mm}, {31'd0, exp_ctrl[2]});
    chk("bubble_wb", {31'd0, bubble_wb}, {31'd0, exp_ctrl[1]});
    chk("flush_id",  {31'd0, flush_id},  {31'd0, exp_ctrl[0]});
    chk("fwd_sel_rs1", {30'd0, fwd_sel_rs1}, {30'd0, m_fwd(id_rs1)});
    chk("fwd_sel_rs2", {30'd0, fwd_sel_rs2}, {30'd0, m_fwd(id_rs2)});
    chk("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_tmo});
    chk("stall_cycles", stall_cycles, m_stalls);
    chk("flush_count", flush_count, m_flush);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy   <= 1'b0;
      m_wait   <= 0;
      m_tmo    <= 1'b0;
      m_stalls <= '0;
      m_flush  <= '0;
    end else begin
      m_busy   <= ex_mc_done ? 1'b0 : (ex_mc_start ? 1'b1 : m_busy);
      m_wait   <= (mm_mem_req && !mm_mem_ready) ? m_wait + 1 : 0;
      m_tmo    <= m_tmo || (mm_mem_req && !mm_mem_ready && m_wait + 1 >= TMO);
      m_stalls <= m_stalls + {31'd0, exp_ctrl[7]};
      m_flush  <= m_flush + {31'd0, exp_ctrl[0]};
    end
  end

  task automatic idle();
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; ex_wr_reg_en = 0; ex_is_load = 0; ex_mc_start = 0; ex_mc_done = 0;
    branch_taken = 0; mm_rd = 0; mm_wr_reg_en = 0; mm_is_load = 0;
    mm_mem_req = 0; mm_mem_ready = 0;
  endtask

  task automatic settle(input string tag);
    @(negedge clk);
    $display("[%0t] txn %s: fwd=%0d/%0d stall_pc=%0b stall_ex=%0b flush=%0b tmo=%0b", $time, tag,
             fwd_sel_rs1, fwd_sel_rs2, stall_pc, stall_ex, flush_id, mem_timeout);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #1 rst_n = 0;
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; ex_rd = 5; ex_wr_reg_en = 1;
    mm_mem_req = 1;
    settle("reset");
    chk("rst_fwd_rs1", {30'd0, fwd_sel_rs1}, 32'd0);
    chk("rst_stall_pc", {31'd0, stall_pc}, 32'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    next(); idle(); rst_n = 1;

    // EX ALU forward, then x0 never forwards
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5; ex_rd = 5; ex_wr_reg_en = 1;
    settle("ex_fwd");
    chk("ex_fwd_sel", {30'd0, fwd_sel_rs1}, 32'd1);
    chk("ex_fwd_nostall", {31'd0, stall_pc}, 32'd0);
    next(); id_rs1 = 0; ex_rd = 0;
    settle("x0");
    chk("x0_sel", {30'd0, fwd_sel_rs1}, 32'd0);
    next();
    // MM ALU forward on rs2, EX beats MM on rs1
    idle(); id_valid = 1; id_rs1 = 9; id_rs2 = 9; ex_rd = 9; ex_wr_reg_en = 1;
    mm_rd = 9; mm_wr_reg_en = 1;
    settle("ex_over_mm");
    chk("ex_over_mm_sel", {30'd0, fwd_sel_rs1}, 32'd1);
    next(); ex_wr_reg_en = 0;
    settle("mm_alu");
    chk("mm_alu_sel", {30'd0, fwd_sel_rs2}, 32'd2);
    next();

    // Load-use: one stall cycle, then MM load forward
    idle(); id_valid = 1; id_uses_rs2 = 1; id_rs2 = 7;
    ex_rd = 7; ex_wr_reg_en = 1; ex_is_load = 1; mm_rd = 7; mm_wr_reg_en = 1;
    settle("load_use");
    chk("lu_stall_pc", {31'd0, stall_pc}, 32'd1);
    chk("lu_bubble_ex", {31'd0, bubble_ex}, 32'd1);
    chk("lu_fwd_file", {30'd0, fwd_sel_rs2}, 32'd0);
    next(); ex_rd = 0; ex_wr_reg_en = 0; ex_is_load = 0; mm_is_load = 1;
    settle("load_fwd");
    chk("lu_next_sel", {30'd0, fwd_sel_rs2}, 32'd3);
    chk("lu_next_nostall", {31'd0, stall_pc}, 32'd0);
    chk("lu_stall_cycles", stall_cycles, 32'd1);
    next();
    // Unused operand or invalid ID does not stall
    idle(); id_valid = 1; id_rs2 = 4; ex_rd = 4; ex_wr_reg_en = 1; ex_is_load = 1;
    settle("lu_unused");
    chk("lu_unused_stall", {31'd0, stall_pc}, 32'd0);
    next(); id_uses_rs2 = 1; id_valid = 0;
    settle("lu_invalid");
    next();

    // Multi-cycle op: 4 stall cycles, none in the done cycle
    idle(); ex_mc_start = 1;
    for (int i = 0; i < 4; i++) begin
      settle("mc_busy");
      chk("mc_stall_ex", {31'd0, stall_ex}, 32'd1);
      chk("mc_bubble_mm", {31'd0, bubble_mm}, 32'd1);
      next(); ex_mc_start = 0;
    end
    ex_mc_done = 1;
    settle("mc_done");
    chk("mc_done_stall_ex", {31'd0, stall_ex}, 32'd0);
    next(); idle();

    // Branch beats load-use
    id_valid = 1; id_uses_rs1 = 1; id_rs1 = 3; ex_rd = 3; ex_wr_reg_en = 1; ex_is_load = 1;
    branch_taken = 1;
    settle("br_lu");
    chk("br_flush", {31'd0, flush_id}, 32'd1);
    chk("br_stall_pc", {31'd0, stall_pc}, 32'd0);
    next(); idle();
    settle("br_after");
    chk("br_flush_count", flush_count, 32'd1);
    next();
    // Branch deferred behind mem wait and behind a multi-cycle op
    branch_taken = 1; mm_mem_req = 1;
    for (int i = 0; i < 2; i++) begin
      settle("br_memwait");
      chk("br_mw_noflush", {31'd0, flush_id}, 32'd0);
      chk("br_mw_bubble_wb", {31'd0, bubble_wb}, 32'd1);
      next();
    end
    mm_mem_ready = 1;
    settle("br_ready");
    chk("br_ready_flush", {31'd0, flush_id}, 32'd1);
    next(); mm_mem_req = 0; mm_mem_ready = 0; ex_mc_start = 1;
    settle("br_mc");
    chk("br_mc_noflush", {31'd0, flush_id}, 32'd0);
    next(); idle();

    // mc_done inside a memory wait still clears the busy flag
    ex_mc_start = 1;
    settle("mc_start");
    next(); ex_mc_start = 0; mm_mem_req = 1; ex_mc_done = 1;
    settle("mc_done_mw");
    next(); idle();
    settle("mc_cleared");
    chk("mc_cleared_stall_ex", {31'd0, stall_ex}, 32'd0);
    next();

    // Timeout after 3 consecutive wait cycles, sticky until reset
    mm_mem_req = 1;
    for (int i = 1; i <= 5; i++) begin
      settle("tmo_wait");
      chk("tmo_during", {31'd0, mem_timeout}, (i > TMO) ? 32'd1 : 32'd0);
      next();
    end
    mm_mem_ready = 1;
    settle("tmo_ready");
    next(); idle();
    settle("tmo_sticky");
    chk("tmo_sticky", {31'd0, mem_timeout}, 32'd1);
    #1 rst_n = 0;
    #1 chk("tmo_reset", {31'd0, mem_timeout}, 32'd0);
    next(); rst_n = 1;

    // Reset mid wait / mid multi-cycle op abandons both
    mm_mem_req = 1; ex_mc_start = 1;
    settle("mw_pre_rst");
    next(); ex_mc_start = 0;
    settle("mw_pre_rst2");
    next(); rst_n = 0;
    settle("mid_reset");
    next(); rst_n = 1;
    for (int i = 0; i < 2; i++) begin
      settle("mw_post_rst");
      next();
    end
    idle();
    settle("post_rst_run");
    chk("post_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("post_rst_stall_ex", {31'd0, stall_ex}, 32'd0);
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
